i2c_scl_gen: RTL and testbench

- Parametrised I2C master SCL/data-strobe generator with clock-stretch support. Successor to the fixed-divider stretch block.
- Adds a runtime divider, explicit four-quarter phase FSM, enable/idle control, stretch timeout with a sticky error, and per-quarter strobes.
- Sits between the I2C byte/bit engine (consumes `data_clk`, `phase`, strobes) and the open-drain SCL pad (drives `scl_oe`, samples `scl_in`).

---
 rtl/i2c_scl_pkg.sv | 37 +++
 rtl/i2c_stretch_timer.sv | 83 ++++++++
 rtl/i2c_scl_gen.sv | 196 +++++++++++++++++++
 tb/tb_i2c_scl_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_scl_pkg.sv
// -----------------------------------------------------------------------------
// i2c_scl_pkg
// Shared types and constants for the I2C SCL / data-strobe generator.
//   scl_state_t  : FSM states (idle plus the four quarters of an SCL period)
//   PH_Q0..PH_Q3 : 2-bit phase codes presented on the phase_o port
//   MIN_DIV      : smallest usable quarter-period in clk cycles
//   state_phase  : maps an FSM state to its phase code (idle reads as Q0)
// -----------------------------------------------------------------------------
package i2c_scl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_Q0   = 3'd1,
        S_Q1   = 3'd2,
        S_Q2   = 3'd3,
        S_Q3   = 3'd4
    } scl_state_t;

    localparam logic [1:0] PH_Q0 = 2'd0;
    localparam logic [1:0] PH_Q1 = 2'd1;
    localparam logic [1:0] PH_Q2 = 2'd2;
    localparam logic [1:0] PH_Q3 = 2'd3;

    localparam int unsigned MIN_DIV = 32'd2;

    function automatic logic [1:0] state_phase(input scl_state_t s);
        logic [1:0] ph;
        case (s)
            S_Q1:    ph = PH_Q1;
            S_Q2:    ph = PH_Q2;
            S_Q3:    ph = PH_Q3;
            default: ph = PH_Q0;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/i2c_stretch_timer.sv
// -----------------------------------------------------------------------------
// i2c_stretch_timer
// Counts clock-stretch cycles inside Q2 and flags a sticky timeout.
//   clk, rst      : clock, synchronous active-high reset
//   load_i        : latch tmo_cfg_i (0 selects DEFAULT_TMO) at the start of a period
//   tmo_cfg_i     : timeout in clk cycles
//   clear_i       : clear the stretch counter (Q2 entry)
//   count_en_i    : current cycle is a stretched cycle
//   enable_i      : generator run request; low for a cycle clears the sticky error
//   expire_o      : this stretched cycle reaches the timeout (combinational)
//   tmo_err_o     : sticky timeout flag (registered)
// -----------------------------------------------------------------------------
module i2c_stretch_timer
    import i2c_scl_pkg::*;
#(
    parameter int TMO_W       = 20,
    parameter int DEFAULT_TMO = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [TMO_W-1:0] tmo_cfg_i,
    input  logic             clear_i,
    input  logic             count_en_i,
    input  logic             enable_i,
    output logic             expire_o,
    output logic             tmo_err_o
);

    localparam logic [TMO_W-1:0] TMO_DEF = TMO_W'(DEFAULT_TMO);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] tcnt_q, tcnt_d;
    logic [TMO_W-1:0] tcnt_inc_s;
    logic             err_q, err_d;

    // Next-state for the timeout latch, stretch counter and sticky error
    always_comb begin
        tcnt_inc_s = tcnt_q + TMO_ONE;
        expire_o   = count_en_i && (tcnt_inc_s == tmo_q);

        tmo_d = tmo_q;
        if (load_i) begin
            tmo_d = (tmo_cfg_i == {TMO_W{1'b0}}) ? TMO_DEF : tmo_cfg_i;
        end else begin
            tmo_d = tmo_q;
        end

        if (clear_i) begin
            tcnt_d = {TMO_W{1'b0}};
        end else if (count_en_i) begin
            tcnt_d = tcnt_inc_s;
        end else begin
            tcnt_d = tcnt_q;
        end

        // Setting wins over clearing so an expiry is never lost
        if (expire_o) begin
            err_d = 1'b1;
        end else if (!enable_i) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q  <= TMO_DEF;
            tcnt_q <= {TMO_W{1'b0}};
            err_q  <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end

    assign tmo_err_o = err_q;

endmodule

// File: rtl/i2c_scl_gen.sv
// -----------------------------------------------------------------------------
// i2c_scl_gen
// I2C master SCL / data-strobe generator with slave clock-stretch support.
// One SCL period is four quarters of div_q clk cycles each:
//   Q0: SCL low,  data_clk 0   Q1: SCL low,      data_clk 1
//   Q2: SCL high, data_clk 1   Q3: SCL high,     data_clk 0
// Q2 is the stretch window: while the bus reads low the quarter counter holds.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   enable_i       : run request; a stop only takes effect at the end of Q3
//   div_cfg_i      : quarter period (0 -> DEFAULT_DIV, clamped to >= MIN_DIV)
//   tmo_cfg_i      : stretch timeout (0 -> DEFAULT_TMO)
//   scl_in_i       : SCL bus level
//   scl_oe_o       : 1 pulls SCL low
//   data_clk_o     : data-phase clock for the bit engine
//   phase_o        : current quarter, 0 when idle
//   busy_o         : not idle
//   q_stb_o        : one-cycle pulse on entry to each quarter
//   stretching_o   : quarter counter frozen by a stretching slave
//   tmo_err_o      : sticky stretch-timeout flag
// Build option: define I2C_SCL_SYNC_EN to pass scl_in_i through a 2-flop
// synchroniser before stretch detection.
// -----------------------------------------------------------------------------
module i2c_scl_gen
    import i2c_scl_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 2500,
    parameter int TMO_W       = 20,
    parameter int DEFAULT_TMO = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic [DIV_W-1:0] div_cfg_i,
    input  logic [TMO_W-1:0] tmo_cfg_i,
    input  logic             scl_in_i,
    output logic             scl_oe_o,
    output logic             data_clk_o,
    output logic [1:0]       phase_o,
    output logic             busy_o,
    output logic             q_stb_o,
    output logic             stretching_o,
    output logic             tmo_err_o
);

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_DIV);
    localparam logic [DIV_W-1:0] DIV_DEF = DIV_W'(DEFAULT_DIV);

    scl_state_t       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             scl_s;
    logic             freeze_s;
    logic             last_s;
    logic             load_s;
    logic             q2_entry_s;
    logic             expire_s;
    logic             tmo_err_s;

`ifdef I2C_SCL_SYNC_EN
    logic [1:0] scl_sync_q;

    // Two-flop synchroniser; resets to the released (high) bus level
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in_i};
        end
    end

    assign scl_s = scl_sync_q[1];
`else
    assign scl_s = scl_in_i;
`endif

    // Next state, quarter counter and divider latch
    always_comb begin
        freeze_s = (state_q == S_Q2) && !scl_s;
        last_s   = (cnt_q == (div_q - DIV_ONE));
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_s   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = {DIV_W{1'b0}};
                if (enable_i && !tmo_err_s) begin
                    state_d = S_Q0;
                    load_s  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_Q0, S_Q1: begin
                if (last_s) begin
                    state_d = (state_q == S_Q0) ? S_Q1 : S_Q2;
                    cnt_d   = {DIV_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end
            S_Q2: begin
                // Timeout abandons the period and releases SCL immediately
                if (expire_s) begin
                    state_d = S_IDLE;
                    cnt_d   = {DIV_W{1'b0}};
                end else if (freeze_s) begin
                    cnt_d = cnt_q;
                end else if (last_s) begin
                    state_d = S_Q3;
                    cnt_d   = {DIV_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end
            S_Q3: begin
                if (last_s) begin
                    cnt_d = {DIV_W{1'b0}};
                    if (enable_i) begin
                        state_d = S_Q0;
                        load_s  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {DIV_W{1'b0}};
            end
        endcase

        q2_entry_s = (state_q == S_Q1) && (state_d == S_Q2);

        // Divider only changes at a period boundary so periods are never mixed
        if (load_s) begin
            if (div_cfg_i == {DIV_W{1'b0}}) begin
                div_d = DIV_DEF;
            end else if (div_cfg_i < DIV_MIN) begin
                div_d = DIV_MIN;
            end else begin
                div_d = div_cfg_i;
            end
        end else begin
            div_d = div_q;
        end
    end

    i2c_stretch_timer #(
        .TMO_W       (TMO_W),
        .DEFAULT_TMO (DEFAULT_TMO)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_s),
        .tmo_cfg_i  (tmo_cfg_i),
        .clear_i    (q2_entry_s),
        .count_en_i (freeze_s),
        .enable_i   (enable_i),
        .expire_o   (expire_s),
        .tmo_err_o  (tmo_err_s)
    );

    // FSM registers; outputs are decoded from the next state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= {DIV_W{1'b0}};
            div_q        <= DIV_DEF;
            scl_oe_o     <= 1'b0;
            data_clk_o   <= 1'b0;
            phase_o      <= PH_Q0;
            busy_o       <= 1'b0;
            q_stb_o      <= 1'b0;
            stretching_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            scl_oe_o     <= (state_d == S_Q0) || (state_d == S_Q1);
            data_clk_o   <= (state_d == S_Q1) || (state_d == S_Q2);
            phase_o      <= state_phase(state_d);
            busy_o       <= (state_d != S_IDLE);
            q_stb_o      <= (state_d != state_q) && (state_d != S_IDLE);
            stretching_o <= freeze_s && !expire_s;
        end
    end

    assign tmo_err_o = tmo_err_s;

endmodule

// File: tb/tb_i2c_scl_gen.sv
`timescale 1ns/1ps
module tb_i2c_scl_gen;

    localparam int DIV_W = 16;
    localparam int TMO_W = 20;

    logic             clk;
    logic             rst;
    logic             enable_i;
    logic [DIV_W-1:0] div_cfg_i;
    logic [TMO_W-1:0] tmo_cfg_i;
    logic             scl_in_i;
    logic             scl_oe_o;
    logic             data_clk_o;
    logic [1:0]       phase_o;
    logic             busy_o;
    logic             q_stb_o;
    logic             stretching_o;
    logic             tmo_err_o;

    typedef struct {
        logic       en;
        logic       scl;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks;
    int   errors;

    i2c_scl_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (2500),
        .TMO_W       (TMO_W),
        .DEFAULT_TMO (100000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (enable_i),
        .div_cfg_i    (div_cfg_i),
        .tmo_cfg_i    (tmo_cfg_i),
        .scl_in_i     (scl_in_i),
        .scl_oe_o     (scl_oe_o),
        .data_clk_o   (data_clk_o),
        .phase_o      (phase_o),
        .busy_o       (busy_o),
        .q_stb_o      (q_stb_o),
        .stretching_o (stretching_o),
        .tmo_err_o    (tmo_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed view: {scl_oe, data_clk, phase[1:0], busy, q_stb, stretching, tmo_err}
    function automatic logic [7:0] pk(input logic oe, input logic dclk, input logic [1:0] ph,
                                      input logic busy, input logic stb, input logic str,
                                      input logic err);
        return {oe, dclk, ph, busy, stb, str, err};
    endfunction

    function automatic logic [7:0] outs();
        return {scl_oe_o, data_clk_o, phase_o, busy_o, q_stb_o, stretching_o, tmo_err_o};
    endfunction

    // Expected outputs i cycles into an unstretched period with a quarter of 4
    function automatic logic [7:0] nominal(input int i);
        int q;
        q = i / 4;
        return pk(q < 2, (q == 1) || (q == 2), 2'(q), 1'b1, (i % 4) == 0, 1'b0, 1'b0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        enable_i = 1'b0;
        scl_in_i = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Cycles spent in quarter ph starting from its entry
    task automatic measure(input logic [1:0] ph, input int maxc, output int n);
        n = 0;
        while (busy_o && (phase_o == ph) && (n < maxc)) begin
            step();
            n++;
        end
    endtask

    task automatic wait_phase(input logic [1:0] ph, input int maxc, output logic ok);
        int n;
        n = 0;
        while (!(busy_o && (phase_o == ph)) && (n < maxc)) begin
            step();
            n++;
        end
        ok = busy_o && (phase_o == ph);
    endtask

    initial begin
        int   n;
        logic ok;
        int   q;
        logic str;
        vec_t v;

        checks = 0;
        errors = 0;

        // Period 1: plain 16-cycle period, quarter = 4
        for (int i = 0; i < 16; i++) begin
            v.en = 1'b1; v.scl = 1'b1; v.exp = nominal(i);
            vecs.push_back(v);
        end
        // Period 2: slave holds SCL low 10 cycles inside Q2 -> 26-cycle period
        for (int i = 0; i < 26; i++) begin
            q = (i < 4) ? 0 : (i < 8) ? 1 : (i < 22) ? 2 : 3;
`ifdef I2C_SCL_SYNC_EN
            str = (i >= 11) && (i <= 20);
`else
            str = (i >= 9) && (i <= 18);
`endif
            v.en  = 1'b1;
            v.scl = !((i >= 9) && (i <= 18));
            v.exp = pk(q < 2, (q == 1) || (q == 2), 2'(q), 1'b1,
                       (i == 0) || (i == 4) || (i == 8) || (i == 22), str, 1'b0);
            vecs.push_back(v);
        end
        // Period 3: enable dropped in Q1, period still completes
        for (int i = 0; i < 16; i++) begin
            v.en = (i < 5); v.scl = 1'b1; v.exp = nominal(i);
            vecs.push_back(v);
        end
        for (int i = 0; i < 2; i++) begin
            v.en = 1'b0; v.scl = 1'b1; v.exp = 8'h00;
            vecs.push_back(v);
        end

        rst       = 1'b1;
        enable_i  = 1'b0;
        scl_in_i  = 1'b1;
        div_cfg_i = 16'd4;
        tmo_cfg_i = 20'd0;
        step();
        step();
        check("reset", outs(), 8'h00);
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            enable_i = vecs[k].en;
            scl_in_i = vecs[k].scl;
            step();
            check($sformatf("vec%0d", k), outs(), vecs[k].exp);
        end

        // Divider change in Q2 only applies from the next Q0
        enable_i = 1'b1;
        step();
        check("restart_q0", outs(), pk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        wait_phase(2'd2, 20, ok);
        check("reach_q2", 32'(ok), 32'd1);
        div_cfg_i = 16'd6;
        measure(2'd2, 20, n); check("midchg_q2_len", n, 4);
        measure(2'd3, 20, n); check("midchg_q3_len", n, 4);
        measure(2'd0, 20, n); check("midchg_q0_len", n, 6);
        measure(2'd1, 20, n); check("midchg_q1_len", n, 6);
        do_reset();

        // div_cfg 0 selects the default quarter
        div_cfg_i = 16'd0;
        enable_i  = 1'b1;
        step();
        measure(2'd0, 3000, n); check("default_q0_len", n, 2500);
        check("default_q1_entry", outs(), pk(1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0));
        do_reset();

        // div_cfg 1 is clamped to a quarter of 2
        div_cfg_i = 16'd1;
        enable_i  = 1'b1;
        step();
        measure(2'd0, 10, n); check("clamp_q0_len", n, 2);
        measure(2'd1, 10, n); check("clamp_q1_len", n, 2);
        measure(2'd2, 10, n); check("clamp_q2_len", n, 2);
        measure(2'd3, 10, n); check("clamp_q3_len", n, 2);
        check("clamp_wrap", outs(), pk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));
        do_reset();

        // Stuck-low SCL: timeout after 8 stretched cycles, then recovery
        div_cfg_i = 16'd4;
        tmo_cfg_i = 20'd8;
        scl_in_i  = 1'b0;
        enable_i  = 1'b1;
        step();
        wait_phase(2'd2, 20, ok);
        check("tmo_reach_q2", 32'(ok), 32'd1);
        for (int i = 0; i < 7; i++) step();
        check("tmo_before", outs(), pk(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0));
        step();
        check("tmo_expire", outs(), pk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        step();
        check("tmo_no_restart", outs(), pk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        enable_i = 1'b0;
        scl_in_i = 1'b1;
        step();
        check("tmo_clear", outs(), 8'h00);
        enable_i = 1'b1;
        step();
        check("tmo_restart", outs(), pk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0));

        // Reset while in Q0
        step();
        rst = 1'b1;
        step();
        check("rst_mid_q0", outs(), 8'h00);
        rst      = 1'b0;
        enable_i = 1'b0;
        step();
        check("rst_stay_idle", outs(), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
